// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle for bit_serializer.
// master: the word producer / observer side (drives load and strobe).
// slave : the serializer itself.
interface bit_serializer_if #(
  parameter int NUM_BITS = 4
) ();

  logic                load_valid;
  logic                load_ready;
  logic [NUM_BITS-1:0] parallel_in;
  logic                shift_strobe;
  logic                serial_out;
  logic                busy;
  logic                done_pulse;

  modport master (
    output load_valid,
    output parallel_in,
    output shift_strobe,
    input  load_ready,
    input  serial_out,
    input  busy,
    input  done_pulse
  );

  modport slave (
    input  load_valid,
    input  parallel_in,
    input  shift_strobe,
    output load_ready,
    output serial_out,
    output busy,
    output done_pulse
  );

endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial shifter feeding a serial pattern detector.
// One NUM_BITS word is accepted per load handshake in IDLE and emitted one bit
// per shift_strobe. serial_out rests at IDLE_VAL between words so idle gaps
// cannot look like pattern bits. done_pulse marks the cycle after the last bit.
// Build option: define SER_LSB_FIRST_EN to emit LSB first (default MSB first).
module bit_serializer #(
  parameter int   NUM_BITS = 4,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              n_rst,
  bit_serializer_if.slave   bus
);

  localparam int               CNT_W    = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [NUM_BITS-1:0] shreg;
  logic [NUM_BITS-1:0] shreg_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                ser;
  logic                ser_nxt;

  // Bit currently at the output end of the shift register.
  function automatic logic head_bit(input logic [NUM_BITS-1:0] w);
`ifdef SER_LSB_FIRST_EN
    return w[0];
`else
    return w[NUM_BITS-1];
`endif
  endfunction

  // Advance the shift register by one position toward the output end.
  function automatic logic [NUM_BITS-1:0] shift_word(input logic [NUM_BITS-1:0] w);
`ifdef SER_LSB_FIRST_EN
    return {1'b0, w[NUM_BITS-1:1]};
`else
    return {w[NUM_BITS-2:0], 1'b0};
`endif
  endfunction

  // State, shift register, bit counter and serial output register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      ser   <= IDLE_VAL;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
      ser   <= ser_nxt;
    end
  end

  // Next-state logic; a load in IDLE wins over a coincident strobe, so the
  // first bit always stays on the line for at least one full cycle.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    ser_nxt   = ser;
    unique case (state)
      IDLE: begin
        if (bus.load_valid) begin
          state_nxt = SHIFT;
          shreg_nxt = bus.parallel_in;
          cnt_nxt   = '0;
          ser_nxt   = head_bit(bus.parallel_in);
        end
      end
      SHIFT: begin
        if (bus.shift_strobe) begin
          if (cnt == LAST_IDX) begin
            state_nxt = DONE;
            ser_nxt   = IDLE_VAL;
          end else begin
            shreg_nxt = shift_word(shreg);
            ser_nxt   = head_bit(shift_word(shreg));
            cnt_nxt   = cnt + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ser_nxt   = IDLE_VAL;
      end
      default: begin
        state_nxt = IDLE;
        ser_nxt   = IDLE_VAL;
      end
    endcase
  end

  assign bus.serial_out = ser;
  assign bus.load_ready = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.done_pulse = (state == DONE);

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: directed latency, strobe-spacing and
// mid-word reset cases, then randomized load/strobe/reset traffic compared
// cycle by cycle against a word-level reference model.
module tb_bit_serializer;

  localparam int   N     = 4;
  localparam logic IDLEV = 1'b0;

  logic clk;
  logic n_rst;
  int   n_tests;
  int   n_fail;

  bit_serializer_if #(.NUM_BITS(N)) bus ();

  bit_serializer #(.NUM_BITS(N), .IDLE_VAL(IDLEV)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: word in flight, index of the bit on the line (-1 none),
  // and whether this is the completion cycle.
  logic [N-1:0] m_word;
  bit           m_busy;
  int           m_idx;
  bit           m_done;

  function automatic logic word_bit(input logic [N-1:0] w, input int k);
`ifdef SER_LSB_FIRST_EN
    return w[k];
`else
    return w[N-1-k];
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_word = '0;
    m_busy = 1'b0;
    m_idx  = -1;
    m_done = 1'b0;
  endtask

  task automatic model_step(input bit lv, input logic [N-1:0] pin, input bit ss);
    if (m_done) begin
      m_done = 1'b0;
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (lv) begin
        m_word = pin;
        m_idx  = 0;
        m_busy = 1'b1;
      end
    end else if (ss) begin
      if (m_idx == N - 1) begin
        m_idx  = -1;
        m_done = 1'b1;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("serial_out", 32'(bus.serial_out),
        32'((m_idx >= 0) ? word_bit(m_word, m_idx) : IDLEV));
    chk("load_ready", 32'(bus.load_ready), 32'(!m_busy));
    chk("busy",       32'(bus.busy),       32'(m_busy));
    chk("done_pulse", 32'(bus.done_pulse), 32'(m_done));
  endtask

  // Drive one cycle of inputs just after a falling edge, clock it in, and
  // compare all outputs at the following falling edge.
  task automatic run_cycle(input bit lv, input logic [N-1:0] pin, input bit ss);
    bus.load_valid   = lv;
    bus.parallel_in  = pin;
    bus.shift_strobe = ss;
    @(posedge clk);
    model_step(lv, pin, ss);
    @(negedge clk);
    check_outputs();
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic pulse_reset();
    n_rst = 1'b0;
    #1;
    model_reset();
    chk("rst_serial", 32'(bus.serial_out), 32'(IDLEV));
    chk("rst_busy",   32'(bus.busy),       32'd0);
    chk("rst_ready",  32'(bus.load_ready), 32'd1);
    chk("rst_done",   32'(bus.done_pulse), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  logic [N-1:0] seq1;
  int           busy_cnt;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.load_valid   = 1'b0;
    bus.parallel_in  = '0;
    bus.shift_strobe = 1'b0;
    model_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    n_rst = 1'b1;

    // Load 1101 with the strobe held high: bits on cycles 1-4, done on 5,
    // ready again on 6.
`ifdef SER_LSB_FIRST_EN
    seq1 = 4'b1101;
`else
    seq1 = 4'b1011;
`endif
    run_cycle(1'b1, 4'b1101, 1'b1);
    chk("t1_bit0", 32'(bus.serial_out), 32'(seq1[0]));
    for (int k = 1; k < N; k++) begin
      run_cycle(1'b0, 4'b0000, 1'b1);
      chk($sformatf("t1_bit%0d", k), 32'(bus.serial_out), 32'(seq1[k]));
    end
    run_cycle(1'b0, 4'b0000, 1'b1);
    chk("t1_done5",  32'(bus.done_pulse), 32'd1);
    chk("t1_ready5", 32'(bus.load_ready), 32'd0);
    run_cycle(1'b0, 4'b0000, 1'b1);
    chk("t1_done6",  32'(bus.done_pulse), 32'd0);
    chk("t1_ready6", 32'(bus.load_ready), 32'd1);

    // Strobe every third cycle on 1011, with a mid-word load of 0000 that
    // must be ignored: busy for exactly 13 cycles.
    busy_cnt = 0;
    run_cycle(1'b1, 4'b1011, 1'b0);
    if (bus.busy) busy_cnt++;
    for (int c = 1; c <= 18; c++) begin
      run_cycle(c == 4, 4'b0000, (c % 3) == 0);
      if (bus.busy) busy_cnt++;
    end
    chk("t3_busy_cycles", 32'(busy_cnt), 32'd13);

    // Reset after bit 1 of 1101, then a fresh word starts from bit 0.
    run_cycle(1'b1, 4'b1101, 1'b0);
    run_cycle(1'b0, 4'b0000, 1'b1);
    pulse_reset();
    run_cycle(1'b0, 4'b0000, 1'b1);
    chk("t5_no_done", 32'(bus.done_pulse), 32'd0);
    run_cycle(1'b1, 4'b0110, 1'b1);
    chk("t5_restart", 32'(bus.serial_out), 32'(word_bit(4'b0110, 0)));

    // Randomized traffic with varying strobe density and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      int dens;
      dens = (i / 500) % 4;
      if ($urandom_range(0, 249) == 0) begin
        pulse_reset();
        check_outputs();
      end else begin
        run_cycle($urandom_range(0, 1) == 1,
                  N'($urandom),
                  $urandom_range(0, dens) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
